led_scan_mux: RTL and testbench
===============================

# led_scan_mux

Time-multiplexed 8-digit seven-segment scanner, directly downstream of `led_driver`. Consumes the eight 6-bit digit fields `{blink, dot, code[3:0]}` that `led_driver` produces. Drives the board's common-anode display: one digit enabled at a time, a one-cycle dead time between digits, and hardware blinking of the digits under edit.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ 2. At 50 MHz this gives 1 ms per slot and an 8 ms frame.
- `BLINK_HALF_FRAMES`, 64: full frames per blink half-period; must be ≥ 1. At the defaults this is ≈ 0.51 s.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `led0`…`led7` in 6 each: digit field `{blink[5], dot[4], code[3:0]}`. `led0` is the rightmost digit.
- `an` out 8: digit enables, active-low; `an[k]` drives digit k.
- `seg` out 8: segments, active-low, bit order `{dp,g,f,e,d,c,b,a}`.

## Operation
- Internal state:
  - `div`: 0..SCAN_DIV-1.
  - `idx`: 0..7.
  - `frm`: 0..BLINK_HALF_FRAMES-1.
  - `phase`: 0 = blink-on, 1 = blink-off.
  - `cap[5:0]`: captured field of the current digit.
- Each clock edge:
  - `div` increments.
  - At SCAN_DIV-1, `div` wraps to 0 and `idx` increments mod 8.
  - When `idx` wraps 7→0, `frm` increments.
  - At BLINK_HALF_FRAMES-1, `frm` wraps to 0 and `phase` toggles.
- Slot start (`div`==0):
  - `cap` ← `led[idx]`. Inputs are sampled only here, so a digit cannot tear mid-slot.
  - `an` ← 8'hFF (dead time, anti-ghosting).
  - `seg` ← 8'hFF.
- Rest of slot:
  - `an` ← `~(8'b1 << idx)`.
  - `seg` ← `encode(cap)`.
- Encoding, active-low, dp off:

  | code | `seg` |
  |---|---|
  | 0 | C0 |
  | 1 | F9 |
  | 2 | A4 |
  | 3 | B0 |
  | 4 | 99 |
  | 5 | 92 |
  | 6 | 82 |
  | 7 | F8 |
  | 8 | 80 |
  | 9 | 90 |
  | A | BF (minus sign) |
  | B–F | FF (blank) |

- Dot: `dot`=1 clears `seg[7]`. Applies to every code, including blank.
- Blink: see Configuration. A blinked-off digit still has its anode enabled; only `seg` is forced to FF.
- No illegal input states exist; every 6-bit field has a defined output.

## Timing
- Reset values:
  - `an`=FF, `seg`=FF.
  - `div`=0, `idx`=0, `frm`=0, `phase`=0, `cap`=0.
- After `rst_n` deasserts:
  - Edge 1 is the digit-0 dead-time edge.
  - Edge 2 drives `an`=FE.
- Each digit is enabled for exactly SCAN_DIV-1 cycles, preceded by 1 all-high cycle.
- Frame period: 8·SCAN_DIV cycles.
- Full blink period: 2·BLINK_HALF_FRAMES frames.
- Latency: a change on `ledk` appears on `seg` at digit k's next slot. This is at most 8·SCAN_DIV+1 cycles.
- Exactly one `an` bit is low at any time, or none.
- `phase` toggles only on a frame boundary, so a blink transition never occurs mid-digit.
- Reset asserted mid-slot: all outputs go to FF immediately (asynchronous), and the scan restarts at digit 0.

## Configuration
- `SEG_BLINK_EN` defined: when `cap[5]`=1 and `phase`=1, `seg` is forced to 8'hFF, dp included.
- `SEG_BLINK_EN` undefined:
  - The blink bit is ignored.
  - `frm` and `phase` logic is not synthesized.
  - `BLINK_HALF_FRAMES` is unused.

## Structure
- Package `seg_pkg`:
  - Field bit positions: `BLINK_BIT`=5, `DOT_BIT`=4.
  - Segment pattern constants: `SEG_0`…`SEG_9`, `SEG_MINUS`, `SEG_BLANK`.
  - Blank code range: B–F.
- Sub-module `seg_decoder`: combinational `{dot, code}` → `seg[7:0]` using the package constants.
- The top-level module owns the counters, capture and output registers.

## Test plan
All scenarios use `SCAN_DIV`=4 and `BLINK_HALF_FRAMES`=2.

- **Reset and dead time:** hold reset, then release.
  - During reset: `an`=FF, `seg`=FF.
  - Edge 1 after release: `an`=FF.
  - Edges 2–4: `an`=FE.
  - Edge 5: `an`=FF.
  - Edge 6: `an`=FD.
  - The 32-cycle frame repeats.
- **Decode, all digits:** drive `led7..led0` = codes 1,2,3,4,5,6,7,8.
  - Each slot shows the matching pattern: digit 0 → 80, digit 7 → F9.
  - Codes A and C show BF and FF.
- **Dot:** `led3`=6'b010000 (code 0, dot on) → `seg`=40 while `an`=F7.
- **Blink (`SEG_BLINK_EN` defined):** `led2`=6'b100101 (blink on, code 5).
  - Frames 0–1: `seg`=92.
  - Frames 2–3: `seg`=FF with `an`=FB.
  - Frames 4–5: `seg`=92 again.
  - Undefined build: `seg`=92 in every frame.
- **No tearing:** change `led1` from 1 to 2 mid-slot of digit 1.
  - The current slot keeps F9.
  - The next frame's digit-1 slot shows A4.
- **Reset mid-operation:** assert `rst_n`=0 during digit 5's slot.
  - `an` and `seg` go to FF without waiting for a clock edge.
  - After release, the first enabled digit is 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment path: digit-field bit positions
// and active-low segment patterns in {dp,g,f,e,d,c,b,a} order.
package seg_pkg;

  localparam int BLINK_BIT = 5;
  localparam int DOT_BIT   = 4;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] CODE_MINUS  = 4'hA;
  localparam logic [3:0] BLANK_FIRST = 4'hB;
  localparam logic [3:0] BLANK_LAST  = 4'hF;

endpackage

// File: rtl/seg_decoder.sv
// Combinational {dot, code} to active-low segment pattern; the dot lights
// on every code, blank included.
module seg_decoder
  import seg_pkg::*;
(
  input  logic       dot,
  input  logic [3:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code) inside
      4'h0:                     seg = SEG_0;
      4'h1:                     seg = SEG_1;
      4'h2:                     seg = SEG_2;
      4'h3:                     seg = SEG_3;
      4'h4:                     seg = SEG_4;
      4'h5:                     seg = SEG_5;
      4'h6:                     seg = SEG_6;
      4'h7:                     seg = SEG_7;
      4'h8:                     seg = SEG_8;
      4'h9:                     seg = SEG_9;
      CODE_MINUS:               seg = SEG_MINUS;
      [BLANK_FIRST:BLANK_LAST]: seg = SEG_BLANK;
      default:                  seg = SEG_BLANK;
    endcase
    if (dot) seg[7] = 1'b0;
  end

endmodule

// File: rtl/led_scan_mux.sv
// 8-digit common-anode scanner with one dead-time cycle per slot.
// Define SEG_BLINK_EN to enable hardware blinking of digits with the blink bit set.
module led_scan_mux
  import seg_pkg::*;
#(
  parameter int SCAN_DIV          = 50000,
  parameter int BLINK_HALF_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] led0,
  input  logic [5:0] led1,
  input  logic [5:0] led2,
  input  logic [5:0] led3,
  input  logic [5:0] led4,
  input  logic [5:0] led5,
  input  logic [5:0] led6,
  input  logic [5:0] led7,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [5:0]       cap;
  logic [5:0]       cur_led;
  logic [7:0]       dec_seg;
  logic             slot_start;
  logic             slot_end;
  logic             frame_end;
  logic             blank_now;

  assign slot_start = (div == '0);
  assign slot_end   = (div == DIV_LAST);
  assign frame_end  = slot_end && (idx == 3'd7);

  always_comb begin
    cur_led = led0;
    case (idx)
      3'd0: cur_led = led0;
      3'd1: cur_led = led1;
      3'd2: cur_led = led2;
      3'd3: cur_led = led3;
      3'd4: cur_led = led4;
      3'd5: cur_led = led5;
      3'd6: cur_led = led6;
      3'd7: cur_led = led7;
      default: cur_led = led0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= 3'd0;
    end else if (slot_end) begin
      div <= '0;
      idx <= idx + 3'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int               FRM_W    = (BLINK_HALF_FRAMES > 1) ? $clog2(BLINK_HALF_FRAMES) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_HALF_FRAMES - 1);

  logic [FRM_W-1:0] frm;
  logic             phase;

  // Phase only moves on a frame boundary, so a digit never blinks mid-slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm   <= '0;
      phase <= 1'b0;
    end else if (frame_end) begin
      if (frm == FRM_LAST) begin
        frm   <= '0;
        phase <= ~phase;
      end else begin
        frm <= frm + FRM_W'(1);
      end
    end
  end

  assign blank_now = cap[BLINK_BIT] & phase;
`else
  localparam int unused_blink_half_frames = BLINK_HALF_FRAMES;
  logic unused_blink;
  logic unused_frame_end;
  assign unused_blink     = cap[BLINK_BIT];
  assign unused_frame_end = frame_end;
  assign blank_now        = 1'b0;
`endif

  seg_decoder u_dec (
    .dot  (cap[DOT_BIT]),
    .code (cap[3:0]),
    .seg  (dec_seg)
  );

  // Inputs are sampled only at slot start, which is also the all-dark dead-time cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= 6'd0;
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else if (slot_start) begin
      cap <= cur_led;
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(8'b1 << idx);
      seg <= blank_now ? 8'hFF : dec_seg;
    end
  end

endmodule

// File: tb/tb_led_scan_mux.sv
// Randomized self-checking bench for led_scan_mux against a slot/frame
// arithmetic model; honours SEG_BLINK_EN when defined.
module tb_led_scan_mux;

  localparam int SCAN_DIV = 4;
  localparam int BHF      = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] led [8];
  logic [7:0] an;
  logic [7:0] seg;

  int checks   = 0;
  int failures = 0;

  int         t;
  int         cur_digit;
  int         cur_pos;
  logic [5:0] cap_model;
  logic [7:0] exp_an;
  logic [7:0] exp_seg;
  bit         rand_en;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] rst_exp [6]  = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD};

  led_scan_mux #(
    .SCAN_DIV          (SCAN_DIV),
    .BLINK_HALF_FRAMES (BHF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .led0  (led[0]),
    .led1  (led[1]),
    .led2  (led[2]),
    .led3  (led[3]),
    .led4  (led[4]),
    .led5  (led[5]),
    .led6  (led[6]),
    .led7  (led[7]),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, observed, expected, t);
    end
  endtask

  function automatic logic [7:0] expSeg(input logic [5:0] f, input int frame);
    logic [7:0] s;
    s = seg_tbl[f[3:0]];
    if (f[4]) s[7] = 1'b0;
`ifdef SEG_BLINK_EN
    if (f[5] && ((frame / BHF) % 2 == 1)) s = 8'hFF;
`endif
    return s;
  endfunction

  // Advance one clock edge, predict outputs from slot/frame arithmetic, check.
  task automatic applyStimulus(input int cycles);
    int slot;
    int frame;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      t++;
      slot      = (t - 1) / SCAN_DIV;
      cur_pos   = (t - 1) % SCAN_DIV;
      cur_digit = slot % 8;
      frame     = slot / 8;
      if (cur_pos == 0) begin
        cap_model = led[cur_digit];
        exp_an    = 8'hFF;
        exp_seg   = 8'hFF;
      end else begin
        exp_an  = ~(8'd1 << cur_digit);
        exp_seg = expSeg(cap_model, frame);
      end
      #1;
      checkOutput("model_an", an, exp_an);
      checkOutput("model_seg", seg, exp_seg);
      if (rand_en && $urandom_range(7) == 0)
        led[$urandom_range(7)] = 6'($urandom);
    end
  endtask

  task automatic runUntil(input int d, input int p);
    int found;
    found = 0;
    for (int i = 0; i < 16 * SCAN_DIV; i++) begin
      applyStimulus(1);
      if (cur_digit == d && cur_pos == p) begin
        found = 1;
        break;
      end
    end
    checkOutput("run_until_bound", 8'(found), 8'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_an", an, 8'hFF);
    checkOutput("reset_seg", seg, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold_an", an, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rand_en = 1'b0;
    t       = 0;
    cap_model = 6'd0;
    for (int k = 0; k < 8; k++) led[k] = 6'd0;

    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOutput("reset_edge_an", an, rst_exp[i]);
    end
    applyStimulus(64 - 6);

    for (int k = 0; k < 8; k++) led[k] = 6'(8 - k);
    applyStimulus(64);
    runUntil(0, 2);
    checkOutput("decode_d0", seg, 8'h80);
    runUntil(7, 2);
    checkOutput("decode_d7", seg, 8'hF9);

    led[4] = 6'h0A;
    led[5] = 6'h0C;
    applyStimulus(32);
    runUntil(4, 2);
    checkOutput("decode_minus", seg, 8'hBF);
    runUntil(5, 2);
    checkOutput("decode_blank", seg, 8'hFF);

    led[3] = 6'b010000;
    applyStimulus(32);
    runUntil(3, 2);
    checkOutput("dot_an", an, 8'hF7);
    checkOutput("dot_seg", seg, 8'h40);

    for (int k = 0; k < 8; k++) led[k] = 6'd0;
    led[2] = 6'b100101;
    doReset();
    for (int f = 0; f < 6; f++) begin
      runUntil(2, 2);
      checkOutput("blink_an", an, 8'hFB);
`ifdef SEG_BLINK_EN
      checkOutput("blink_seg", seg, ((f / 2) % 2 == 1) ? 8'hFF : 8'h92);
`else
      checkOutput("blink_seg", seg, 8'h92);
`endif
    end

    led[1] = 6'd1;
    applyStimulus(40);
    runUntil(1, 2);
    led[1] = 6'd2;
    applyStimulus(1);
    checkOutput("tear_hold", seg, 8'hF9);
    runUntil(1, 2);
    checkOutput("tear_next", seg, 8'hA4);

    rand_en = 1'b1;
    applyStimulus(400);
    rand_en = 1'b0;

    runUntil(5, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_an", an, 8'hFF);
    checkOutput("midrst_seg", seg, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_hold", an, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    applyStimulus(2);
    checkOutput("midrst_first", an, 8'hFE);
    applyStimulus(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
